sha256_result_checker: RTL and testbench



---
 rtl/sha256_result_checker.sv | 110 +++++++++++
 tb/tb_sha256_result_checker.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sha256_result_checker.sv
// sha256_result_checker: reassembles digests, counts leading zeros, tracks best nonce against a target
module sha256_result_checker #(
  parameter int NUM_NONCES = 16,
  parameter int NONCE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [8:0]         target_zeros,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NONCE_W-1:0] in_nonce,
  input  logic [2:0]         in_idx,
  input  logic [31:0]        in_word,
  output logic               found,
  output logic [NONCE_W-1:0] best_nonce,
  output logic [8:0]         best_lz,
  output logic [255:0]       best_digest,
  output logic               done,
  output logic               error
);
  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DONE} state_t;
  state_t state;
  logic [8:0] tgt, lz_acc;
  logic [NONCE_W-1:0] exp_nonce;
  logic [2:0] exp_idx;
  logic all_zero, xfer, order_ok, last_nonce;
  logic [255:0] dig;
  logic [5:0] clz;
  always_comb begin
    xfer = in_valid && in_ready;
    order_ok = (in_nonce == exp_nonce) && (in_idx == exp_idx);
    last_nonce = exp_nonce == NONCE_W'(NUM_NONCES - 1);
    clz = 6'd32;
    for (int i = 0; i < 32; i++) clz = in_word[i] ? 6'(31 - i) : clz;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tgt <= '0;
      lz_acc <= '0;
      exp_nonce <= '0;
      exp_idx <= '0;
      all_zero <= 1'b0;
      dig <= '0;
      in_ready <= 1'b0;
      found <= 1'b0;
      best_nonce <= '0;
      best_lz <= '0;
      best_digest <= '0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          tgt <= target_zeros;
          found <= 1'b0;
          done <= 1'b0;
          error <= 1'b0;
          best_nonce <= '0;
          best_lz <= '0;
          best_digest <= '0;
          exp_nonce <= '0;
          exp_idx <= '0;
          lz_acc <= '0;
          all_zero <= 1'b1;
          in_ready <= 1'b1;
          state <= COLLECT;
        end
        COLLECT: if (xfer) begin
          if (!order_ok) begin
            error <= 1'b1;
            in_ready <= 1'b0;
            state <= DONE;
          end else begin
            dig[{~in_idx, 5'd0} +: 32] <= in_word;
            if (all_zero) begin
              lz_acc <= lz_acc + {3'b0, clz};
              all_zero <= in_word == 32'd0;
            end
            if (in_idx == 3'd7) begin
              in_ready <= 1'b0;
              state <= CHECK;
            end else exp_idx <= exp_idx + 3'd1;
          end
        end
        CHECK: begin
          if (lz_acc >= tgt) found <= 1'b1;
          if (lz_acc > best_lz || exp_nonce == '0) begin
            best_nonce <= exp_nonce;
            best_lz <= lz_acc;
            best_digest <= dig;
          end
          lz_acc <= '0;
          all_zero <= 1'b1;
          exp_idx <= '0;
          if (last_nonce) begin
            done <= 1'b1;
            state <= DONE;
          end else begin
            exp_nonce <= exp_nonce + NONCE_W'(1);
            in_ready <= 1'b1;
            state <= COLLECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_result_checker.sv
// tb_sha256_result_checker: randomized sweeps checked against a bitwise leading-zero reference model
module tb_sha256_result_checker;
  localparam int N = 16;
  logic clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [8:0] target_zeros = '0;
  logic [3:0] in_nonce = '0;
  logic [2:0] in_idx = '0;
  logic [31:0] in_word = '0;
  logic in_ready, found, done, error;
  logic [3:0] best_nonce;
  logic [8:0] best_lz;
  logic [255:0] best_digest;
  logic [255:0] dg [N];
  int nvec = 0, nerr = 0;
  sha256_result_checker #(.NUM_NONCES(N), .NONCE_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .target_zeros(target_zeros),
    .in_valid(in_valid), .in_ready(in_ready), .in_nonce(in_nonce), .in_idx(in_idx),
    .in_word(in_word), .found(found), .best_nonce(best_nonce), .best_lz(best_lz),
    .best_digest(best_digest), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int lz256(input logic [255:0] d);
    for (int b = 255; b >= 0; b--) if (d[b]) return 255 - b;
    return 256;
  endfunction
  function automatic logic [31:0] rnd_word();
    return ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
  endfunction
  task automatic model(input int cnt, input int tgt, output logic f, output int bn, output int bl);
    f = 0; bn = 0; bl = -1;
    for (int n = 0; n < cnt; n++) begin
      int lz = lz256(dg[n]);
      if (lz >= tgt) f = 1;
      if (lz > bl) begin bl = lz; bn = n; end
    end
  endtask
  task automatic check_out(input string tag, input logic f, input int bn, input int bl, input logic dn, input logic er);
    check({tag, "_found"}, 256'(found), 256'(f));
    check({tag, "_nonce"}, 256'(best_nonce), 256'(bn));
    check({tag, "_lz"}, 256'(best_lz), 256'(bl));
    check({tag, "_digest"}, best_digest, dg[bn]);
    check({tag, "_done"}, 256'(done), 256'(dn));
    check({tag, "_error"}, 256'(error), 256'(er));
    check({tag, "_ready"}, 256'(in_ready), 256'(0));
  endtask
  task automatic start_sweep(input int tgt);
    start = 1; target_zeros = 9'(tgt);
    @(negedge clk);
    start = 0;
  endtask
  task automatic send(input int n, input int i, input logic [31:0] w, input bit gap);
    int t = 0;
    if (gap) @(negedge clk);
    in_valid = 1; in_nonce = 4'(n); in_idx = 3'(i); in_word = w;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (!in_ready) check("ready_timeout", 256'(in_ready), 256'(1));
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic sweep(input int tgt, input bit gap, input string tag);
    logic f; int bn, bl;
    start_sweep(tgt);
    for (int n = 0; n < N; n++)
      for (int i = 0; i < 8; i++) send(n, i, dg[n][(7 - i) * 32 +: 32], gap);
    @(negedge clk);
    model(N, tgt, f, bn, bl);
    check_out(tag, f, bn, bl, 1'b1, 1'b0);
  endtask
  task automatic fill_ff();
    for (int n = 0; n < N; n++) dg[n] = '1;
  endtask
  task automatic fill_rnd();
    for (int n = 0; n < N; n++)
      for (int i = 0; i < 8; i++) dg[n][i * 32 +: 32] = rnd_word();
  endtask
  initial begin
    logic f; int bn, bl;
    repeat (2) @(negedge clk);
    reset = 0;
    check("rst_ready", 256'(in_ready), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_error", 256'(error), 256'(0));
    check("rst_lz", 256'(best_lz), 256'(0));
    check("rst_digest", best_digest, 256'(0));
    start_sweep(0);
    check("start_ready", 256'(in_ready), 256'(1));
    reset = 1; @(negedge clk); reset = 0;
    fill_ff(); dg[5][255:224] = 32'h00FFFFFF;
    sweep(8, 0, "t8");
    check("t8_word0", 256'(best_digest[255:224]), 256'(32'h00FFFFFF));
    fill_ff(); dg[3][255:224] = 32'h0; dg[3][223:192] = 32'h0000FFFF;
    sweep(49, 0, "t49");
    sweep(48, 0, "t48");
    fill_ff(); dg[2][255:224] = 32'h0FFFFFFF; dg[9][255:224] = 32'h0FFFFFFF;
    sweep(0, 1, "tie");
    dg[11] = '0;
    sweep(300, 0, "allzero");
    for (int r = 0; r < 6; r++) begin
      fill_rnd();
      sweep($urandom_range(0, 300), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end
    fill_rnd();
    start_sweep(0);
    for (int i = 0; i < 8; i++) send(0, i, dg[0][(7 - i) * 32 +: 32], 0);
    send(1, 0, 32'h1, 0); send(1, 1, 32'h2, 0); send(1, 3, 32'h3, 0);
    model(1, 0, f, bn, bl);
    check_out("err", f, bn, bl, 1'b0, 1'b1);
    start_sweep(8);
    check("err_clear", 256'(error), 256'(0));
    check("err_clear_ready", 256'(in_ready), 256'(1));
    fill_rnd();
    for (int n = 0; n < 7; n++)
      for (int i = 0; i < 8; i++) send(n, i, dg[n][(7 - i) * 32 +: 32], 0);
    for (int i = 0; i < 4; i++) send(7, i, dg[7][(7 - i) * 32 +: 32], 0);
    in_valid = 1; in_nonce = 4'd7; in_idx = 3'd4; in_word = dg[7][95:64]; reset = 1;
    @(negedge clk);
    in_valid = 0;
    check("mid_ready", 256'(in_ready), 256'(0));
    check("mid_found", 256'(found), 256'(0));
    check("mid_nonce", 256'(best_nonce), 256'(0));
    check("mid_lz", 256'(best_lz), 256'(0));
    check("mid_digest", best_digest, 256'(0));
    check("mid_done", 256'(done), 256'(0));
    check("mid_error", 256'(error), 256'(0));
    reset = 0;
    fill_rnd();
    sweep(20, 0, "after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
